// File: rtl/aes_round_seq_pkg.sv
// Shared types and helpers for the iterative AES-style round sequencer.
// Holds the FSM state enum, datapath width, default round/index sizes and GF(2^8) helpers.
package aes_round_seq_pkg;

    localparam int STATE_W = 256;
    localparam int COLS    = STATE_W / 32;
    localparam int NR_DEF  = 14;
    localparam int KW_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        KEY0  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Multiply by x in GF(2^8) with the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One column, most significant byte is row 0.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

endpackage

// File: rtl/aes_round_seq_mixcol.sv
// Combinational column mixer over the full 256-bit state.
// Ports: data_i (state in, column 0 in bits [255:224]), data_o (mixed state).
module aes_round_seq_mixcol
    import aes_round_seq_pkg::*;
(
    input  logic [STATE_W-1:0] data_i,
    output logic [STATE_W-1:0] data_o
);

    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int HI = STATE_W - 1 - 32 * c;
        assign data_o[HI -: 32] = mix_column(data_i[HI -: 32]);
    end

endmodule

// File: rtl/aes_round_seq.sv
// Iterative round sequencer: state register, round counter, round-key fetch and loop through external SubBytes/ShiftRows.
// Ports: start_valid/start_ready/din in, done_valid/done_ready/dout out, key_req/key_idx/key_ack/key_data, ss_out/ss_in, busy, round_idx.
module aes_round_seq
    import aes_round_seq_pkg::*;
#(
    parameter int NR = NR_DEF,
    parameter int KW = KW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [STATE_W-1:0] din,
    output logic               done_valid,
    input  logic               done_ready,
    output logic [STATE_W-1:0] dout,
    output logic               busy,
    output logic [KW-1:0]      round_idx,
    output logic               key_req,
    output logic [KW-1:0]      key_idx,
    input  logic               key_ack,
    input  logic [STATE_W-1:0] key_data,
    output logic [STATE_W-1:0] ss_out,
    input  logic [STATE_W-1:0] ss_in
);

    localparam logic [KW-1:0] LAST = KW'(NR);

    state_e             fsm_q, fsm_d;
    logic [STATE_W-1:0] data_q, data_d;
    logic [KW-1:0]      round_q, round_d;
    logic [STATE_W-1:0] mix_out;

    aes_round_seq_mixcol u_mixcol (
        .data_i (ss_in),
        .data_o (mix_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= IDLE;
            data_q  <= '0;
            round_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            data_q  <= data_d;
            round_q <= round_d;
        end
    end

    always_comb begin
        fsm_d       = fsm_q;
        data_d      = data_q;
        round_d     = round_q;
        start_ready = 1'b0;
        done_valid  = 1'b0;
        key_req     = 1'b0;
        key_idx     = '0;
        unique case (fsm_q)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    data_d = din;
                    fsm_d  = KEY0;
                end
            end
            KEY0: begin
                key_req = 1'b1;
                if (key_ack) begin
                    data_d  = data_q ^ key_data;
                    round_d = KW'(1);
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                key_req = 1'b1;
                key_idx = round_q;
                if (key_ack) begin
                    // Final round skips the column mix.
                    if (round_q == LAST) begin
                        data_d = ss_in ^ key_data;
                        fsm_d  = DONE;
                    end else begin
                        data_d  = mix_out ^ key_data;
                        round_d = round_q + KW'(1);
                    end
                end
            end
            DONE: begin
                done_valid = 1'b1;
                if (done_ready) begin
                    round_d = '0;
                    fsm_d   = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign busy      = (fsm_q != IDLE);
    assign round_idx = round_q;
    assign dout      = data_q;
    assign ss_out    = data_q;

endmodule

// File: tb/tb_aes_round_seq.sv
// Directed self-checking bench for aes_round_seq with NR=2.
// External SubBytes/ShiftRows is modelled as ss_in = ss_out ^ ss_mask.
module tb_aes_round_seq;

    localparam int NR = 2;
    localparam int KW = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic [255:0] din;
    logic         done_valid;
    logic         done_ready;
    logic [255:0] dout;
    logic         busy;
    logic [KW-1:0] round_idx;
    logic         key_req;
    logic [KW-1:0] key_idx;
    logic         key_ack;
    logic [255:0] key_data;
    logic [255:0] ss_out;
    logic [255:0] ss_in;

    logic [255:0] k0, k1, k2, ss_mask;
    int errors = 0;
    int checks = 0;
    int cyc;

    localparam logic [255:0] ALL_FF = {32{8'hff}};
    localparam logic [255:0] COL_DB = {8{32'hdb135345}};
    localparam logic [255:0] COL_8E = {8{32'h8e4da1bc}};
    localparam logic [255:0] COL_55 = {8{32'h555ef2f9}};

    always #5 clk = ~clk;

    assign ss_in = ss_out ^ ss_mask;

    always_comb begin
        key_data = k2;
        if (key_idx == 4'd0) key_data = k0;
        else if (key_idx == 4'd1) key_data = k1;
    end

    aes_round_seq #(.NR(NR), .KW(KW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .din         (din),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .dout        (dout),
        .busy        (busy),
        .round_idx   (round_idx),
        .key_req     (key_req),
        .key_idx     (key_idx),
        .key_ack     (key_ack),
        .key_data    (key_data),
        .ss_out      (ss_out),
        .ss_in       (ss_in)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    // Leaves the bench at the negedge after the acceptance edge.
    task automatic start_blk(input logic [255:0] d);
        @(negedge clk);
        start_valid = 1'b1;
        din = d;
        @(negedge clk);
        start_valid = 1'b0;
        cyc = 1;
    endtask

    task automatic wait_done();
        while (!done_valid && cyc < 100) tick();
        chk("done_seen", done_valid, 1);
    endtask

    task automatic release_blk();
        @(negedge clk);
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
        chk("rel_ready", start_ready, 1);
        chk("rel_busy", busy, 0);
        chk("rel_round", round_idx, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_start_ready"}, start_ready, 1);
        chk({tag, "_done_valid"}, done_valid, 0);
        chk({tag, "_key_req"}, key_req, 0);
        chk({tag, "_key_idx"}, key_idx, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_round"}, round_idx, 0);
        chk({tag, "_dout"}, dout, 0);
    endtask

    initial begin
        rst = 1'b1;
        start_valid = 1'b0;
        done_ready = 1'b0;
        key_ack = 1'b1;
        din = '0;
        k0 = ALL_FF;
        k1 = '0;
        k2 = '0;
        ss_mask = '0;
        cyc = 0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;

        // key0 all FF, other keys zero
        start_blk('0);
        chk("t1_keyreq", key_req, 1);
        wait_done();
        chk("t1_lat", cyc, NR + 2);
        chk("t1_dout", dout, ALL_FF);
        release_blk();

        // column mixing after round 1, plain final round
        k0 = COL_DB;
        start_blk('0);
        tick();
        chk("t2_r1_state", dout, COL_DB);
        chk("t2_r1_idx", round_idx, 1);
        tick();
        chk("t2_r2_state", dout, COL_8E);
        chk("t2_r2_keyidx", key_idx, 2);
        wait_done();
        chk("t2_lat", cyc, NR + 2);
        chk("t2_dout", dout, COL_8E);
        release_blk();

        // five-cycle key stall in round 1
        start_blk('0);
        tick();
        key_ack = 1'b0;
        repeat (5) begin
            tick();
            chk("t3_state", dout, COL_DB);
            chk("t3_round", round_idx, 1);
            chk("t3_keyidx", key_idx, 1);
        end
        key_ack = 1'b1;
        wait_done();
        chk("t3_lat", cyc, NR + 2 + 5);
        chk("t3_dout", dout, COL_8E);

        // result held under back-pressure, start ignored
        start_valid = 1'b1;
        din = {32{8'h5a}};
        repeat (4) begin
            tick();
            chk("t4_dout", dout, COL_8E);
            chk("t4_ready", start_ready, 0);
            chk("t4_valid", done_valid, 1);
        end
        k0 = ALL_FF;
        din = '0;
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        chk("t4_idle_busy", busy, 0);
        chk("t4_idle_ready", start_ready, 1);
        tick();
        start_valid = 1'b0;
        chk("t4_accept", busy, 1);
        cyc = 1;
        wait_done();
        chk("t4_lat", cyc, NR + 2);
        chk("t4_dout", dout, ALL_FF);
        release_blk();

        // asynchronous reset in round 1
        k0 = COL_DB;
        start_blk('0);
        tick();
        chk("t5_pre_round", round_idx, 1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("t5");
        #1 rst = 1'b0;
        start_blk('0);
        wait_done();
        chk("t5_lat", cyc, NR + 2);
        chk("t5_dout", dout, COL_8E);
        release_blk();

        // key_ack toggling in IDLE does nothing
        key_ack = 1'b0;
        tick();
        key_ack = 1'b1;
        tick();
        key_ack = 1'b0;
        tick();
        chk("t6_busy", busy, 0);
        chk("t6_keyreq", key_req, 0);
        chk("t6_round", round_idx, 0);
        chk("t6_state", dout, COL_8E);
        key_ack = 1'b1;

        // non-identity SubBytes/ShiftRows path
        k0 = '0;
        ss_mask = COL_DB;
        start_blk('0);
        wait_done();
        chk("t7_dout", dout, COL_55);
        release_blk();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
